// File: rtl/mult_exp_sequencer.sv
// FP multiplier exponent sequencer: adds exponents, subtracts bias, and flags overflow/underflow on one shared adder.
// Latency is 4 cycles from start to done. No queueing: start is ignored while busy. Optional abort_i port via MULT_EXP_ABORT_EN.
`timescale 1ns/1ps
module mult_exp_sequencer #(
    parameter int W_Exp = 8,
    parameter int BIAS  = 127
) (
    input  logic             clk_i,
    input  logic             rst_i,
`ifdef MULT_EXP_ABORT_EN
    input  logic             abort_i,
`endif
    input  logic             start_i,
    input  logic [W_Exp-1:0] exp_x_i,
    input  logic [W_Exp-1:0] exp_y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [W_Exp:0]   exp_result_o,
    output logic             overflow_o,
    output logic             underflow_o
);
    typedef enum logic [1:0] {S_IDLE, S_ADD, S_SUB, S_FLAG} state_t;

    localparam logic [W_Exp+1:0] BIAS_W  = (W_Exp+2)'(BIAS);
    localparam logic [W_Exp+1:0] OVF_LIM = (W_Exp+2)'((1 << W_Exp) - 1);

    state_t             state_q;
    logic [W_Exp-1:0]   opx_q, opy_q;
    logic [W_Exp:0]     sum_q, sum_d;
    logic [W_Exp+1:0]   diff_q, diff_d;
    logic [W_Exp:0]     exp_result_q;
    logic               done_q, ovf_q, unf_q;
    logic               abort_w, is_unf, is_ovf;

`ifdef MULT_EXP_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    assign sum_d  = {1'b0, opx_q} + {1'b0, opy_q};
    assign diff_d = {1'b0, sum_q} - BIAS_W;
    // diff is two's complement: sign bit or zero both mean the exponent fell below range.
    assign is_unf = diff_q[W_Exp+1] || (diff_q == '0);
    assign is_ovf = !diff_q[W_Exp+1] && (diff_q >= OVF_LIM);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            opx_q        <= '0;
            opy_q        <= '0;
            sum_q        <= '0;
            diff_q       <= '0;
            exp_result_q <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_w && state_q != S_IDLE) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            opx_q   <= exp_x_i;
                            opy_q   <= exp_y_i;
                            state_q <= S_ADD;
                        end
                    end
                    S_ADD: begin
                        sum_q   <= sum_d;
                        state_q <= S_SUB;
                    end
                    S_SUB: begin
                        diff_q  <= diff_d;
                        state_q <= S_FLAG;
                    end
                    S_FLAG: begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                        if (is_unf) begin
                            exp_result_q <= '0;
                            unf_q        <= 1'b1;
                            ovf_q        <= 1'b0;
                        end else if (is_ovf) begin
                            exp_result_q <= {1'b0, {W_Exp{1'b1}}};
                            unf_q        <= 1'b0;
                            ovf_q        <= 1'b1;
                        end else begin
                            exp_result_q <= diff_q[W_Exp:0];
                            unf_q        <= 1'b0;
                            ovf_q        <= 1'b0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign exp_result_o = exp_result_q;
    assign overflow_o   = ovf_q;
    assign underflow_o  = unf_q;
endmodule
